serial_signed_sub_with_saturation: RTL and testbench
====================================================

Name: serial_signed_sub_with_saturation

Overview:
- Bit-serial, multi-cycle signed subtractor: computes diff = a - b in two's complement, LSB first, one bit per clock.
- Clamps the result to the representable range on overflow.
- Counterpart of the team's combinational saturating adder, for area-constrained datapaths.
- Sits between a valid/ready producer and a valid/ready consumer; one operation in flight at a time.

Parameters:
- WIDTH, 4, operand/result width in bits, signed two's complement; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_valid  input  1  operands a, b valid.
- up_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, signed.
- b  input  WIDTH  subtrahend, signed.
- down_valid  output  1  result valid.
- down_ready  input  1  consumer accepts result.
- diff  output  WIDTH  saturated a - b, signed.
- sat  output  1  high when diff was clamped.

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low. Assertion of rst_n=0 immediately forces state IDLE, down_valid=0, diff=0, sat=0, bit counter=0, carry=1, and internal operand registers to 0. After release, up_ready=1. An in-flight operation is discarded with no output.
- States:
  - IDLE: up_ready=1, down_valid=0. On up_valid && up_ready at edge E0:
    - latch a into a_sh and ~b into b_sh;
    - set carry=1, count=0, record a_msb=a[WIDTH-1] and b_msb=b[WIDTH-1];
    - go to CALC.
  - CALC: up_ready=0, down_valid=0. Each edge:
    - r = a_sh[0] ^ b_sh[0] ^ carry;
    - carry = majority(a_sh[0], b_sh[0], carry);
    - shift a_sh and b_sh right by 1;
    - shift r into the MSB of the result register;
    - count++.
    On the edge where count==WIDTH-1, the last bit is produced and state goes to DONE. diff and sat are loaded on that same edge, already saturated.
  - DONE: down_valid=1, up_ready=0. diff and sat are held stable until down_ready=1. On down_valid && down_ready, go to IDLE. up_ready rises the cycle after the result handshake; an operand is never accepted in the same cycle as a result handshake.
- Saturation: let r_msb be the raw MSB of the result.
  - a_msb=0, b_msb=1, r_msb=1: diff = 0 followed by all ones (max positive), sat=1.
  - a_msb=1, b_msb=0, r_msb=0: diff = 1 followed by all zeros (min negative), sat=1.
  - Otherwise: diff = raw result, sat=0.
  - Equal operand signs never saturate.
- Latency: down_valid rises WIDTH edges after the accepting edge (E0+WIDTH). Minimum issue interval is WIDTH+2 cycles.
- Input handling:
  - a and b are sampled only at the accept edge; later changes are ignored.
  - up_valid while busy is ignored; the producer must hold it.
- Outputs: all outputs except up_ready are registered. up_ready is decoded from state only and has no combinational path from any input.
- Width behaviour: all arithmetic is modulo 2^WIDTH before saturation; no sign extension inside the block.

Decomposition:
- Package serial_sub_pkg:
  - state enum typedef (IDLE, CALC, DONE);
  - function max_pos(WIDTH) returning 0 followed by all ones;
  - function min_neg(WIDTH) returning 1 followed by all zeros.
- Sub-module serial_sub_bit: combinational one-bit full-adder cell. Inputs a_bit, nb_bit, cin; outputs s, cout. Instantiated once in CALC datapath.
- Counter width is $clog2(WIDTH).

Test Plan (WIDTH=4, down_ready=1 unless stated):
- 1. a=3, b=2 accepted at edge E0 → down_valid first seen high after edge E0+4, diff=1, sat=0; up_ready low from E0+1 through the result handshake.
- 2. a=7, b=-1 (4'b1111) → diff=7 (4'b0111), sat=1. a=-8, b=1 → diff=-8 (4'b1000), sat=1.
- 3. a=-8, b=-8 → diff=0, sat=0. a=-1, b=7 → diff=-8, sat=0 (exact, no clamp). a=0, b=-8 → diff=7, sat=1.
- 4. Backpressure: a=5, b=6 with down_ready=0 for 5 cycles after down_valid → diff=-1 (4'b1111) and sat=0 held stable with down_valid=1. up_valid held high with a=1, b=1 is not accepted. After down_ready=1, next op accepted one cycle later and yields diff=0.
- 5. Reset mid-CALC: accept a=7, b=-8; pull rst_n low two cycles later, asynchronously between edges → down_valid=0, diff=0, sat=0 immediately. After release, up_ready=1 and no stale result appears. A new op a=2, b=3 yields diff=-1.
- 6. Randomized operands for all 256 pairs, back-to-back issue → every diff equals clamp(a-b, -8, 7), sat matches clamp activity, issue interval exactly 6 cycles.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and saturation limits for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers truncate the 64-bit result to their own WIDTH.
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/serial_sub_bit.sv
// rtl/serial_sub_bit.sv - one-bit full-adder cell fed with the inverted subtrahend bit
module serial_sub_bit (
  input  logic a_bit,
  input  logic nb_bit,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a_bit ^ nb_bit ^ cin;
  assign cout = (a_bit & nb_bit) | (a_bit & cin) | (nb_bit & cin);

endmodule

// File: rtl/serial_signed_sub_with_saturation.sv
// rtl/serial_signed_sub_with_saturation.sv - LSB-first serial a - b with clamp to the signed range
module serial_signed_sub_with_saturation #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] diff,
  output logic             sat
);
  import serial_sub_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] raw;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             r;
  logic             cout;
  logic             last;
  logic             pos_ovf;
  logic             neg_ovf;

  serial_sub_bit u_bit (
    .a_bit  (a_sh[0]),
    .nb_bit (b_sh[0]),
    .cin    (carry),
    .s      (r),
    .cout   (cout)
  );

  assign up_ready = (state == IDLE);
  assign last     = (state == CALC) && (count == CW'(WIDTH - 1));
  assign raw      = {r, res[WIDTH-1:1]};
  // Overflow is only possible when the operand signs differ.
  assign pos_ovf  = !a_msb &&  b_msb &&  r;
  assign neg_ovf  =  a_msb && !b_msb && !r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (up_valid)   state_nxt = CALC;
      CALC:    if (last)       state_nxt = DONE;
      DONE:    if (down_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      count      <= '0;
      carry      <= 1'b1;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      down_valid <= 1'b0;
      diff       <= '0;
      sat        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            a_sh  <= a;
            b_sh  <= ~b;
            carry <= 1'b1;
            count <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        CALC: begin
          carry <= cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= raw;
          count <= count + 1'b1;
          if (last) begin
            down_valid <= 1'b1;
            sat        <= pos_ovf || neg_ovf;
            if (pos_ovf)      diff <= WIDTH'(max_pos(WIDTH));
            else if (neg_ovf) diff <= WIDTH'(min_neg(WIDTH));
            else              diff <= raw;
          end
        end
        DONE: begin
          if (down_ready) down_valid <= 1'b0;
        end
        default: begin
          down_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_signed_sub_with_saturation.sv
// tb/tb_serial_signed_sub_with_saturation.sv - directed and exhaustive checks of the serial saturating subtractor
module tb_serial_signed_sub_with_saturation;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         down_valid;
  logic         down_ready = 1'b1;
  logic [W-1:0] diff;
  logic         sat;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_accept = -1;

  serial_signed_sub_with_saturation #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .a          (a),
    .b          (b),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .diff       (diff),
    .sat        (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for the result, and check it plus latency and up_ready.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_diff, input logic exp_sat,
                        input logic check_interval);
    int lat;
    a = av;
    b = bv;
    up_valid = 1'b1;
    chk({tag, "_up_ready_idle"}, up_ready, 1);
    step();
    if (check_interval && last_accept >= 0) chk({tag, "_interval"}, cycle - last_accept, W + 2);
    last_accept = cycle;
    up_valid = 1'b0;
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    lat = 0;
    while (!down_valid && lat < 20) begin
      if (up_ready) chk({tag, "_up_ready_busy"}, up_ready, 0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_diff"}, diff, exp_diff);
    chk({tag, "_sat"}, sat, exp_sat);
    chk({tag, "_up_ready_done"}, up_ready, 0);
    step();
    chk({tag, "_valid_drop"}, down_valid, 0);
    chk({tag, "_up_ready_back"}, up_ready, 1);
  endtask

  initial begin
    int da;
    int db;
    int d;
    logic [W-1:0] ed;
    logic es;

    #2;
    chk("rst_down_valid", down_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_sat", sat, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_up_ready", up_ready, 1);

    run_op("t1_3m2", 4'd3, 4'd2, 4'd1, 1'b0, 1'b0);
    run_op("t2_7m_1", 4'd7, 4'hF, 4'h7, 1'b1, 1'b0);
    run_op("t2_m8m1", 4'h8, 4'd1, 4'h8, 1'b1, 1'b0);
    run_op("t3_m8mm8", 4'h8, 4'h8, 4'h0, 1'b0, 1'b0);
    run_op("t3_m1m7", 4'hF, 4'd7, 4'h8, 1'b0, 1'b0);
    run_op("t3_0mm8", 4'd0, 4'h8, 4'h7, 1'b1, 1'b0);

    // Backpressure: result must hold while an operand waits unaccepted.
    down_ready = 1'b0;
    a = 4'd5;
    b = 4'd6;
    up_valid = 1'b1;
    step();
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < 20 && !down_valid; i++) step();
    chk("t4_valid_up", down_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", down_valid, 1);
      chk("t4_hold_diff", diff, 4'hF);
      chk("t4_hold_sat", sat, 0);
      chk("t4_hold_up_ready", up_ready, 0);
      step();
    end
    down_ready = 1'b1;
    step();
    chk("t4_handshake_valid", down_valid, 0);
    chk("t4_handshake_up_ready", up_ready, 1);
    step();
    chk("t4_accepted", up_ready, 0);
    up_valid = 1'b0;
    for (int i = 0; i < 20 && !down_valid; i++) step();
    chk("t4_next_valid", down_valid, 1);
    chk("t4_next_diff", diff, 4'h0);
    chk("t4_next_sat", sat, 0);
    step();

    // Asynchronous reset in the middle of a calculation.
    a = 4'd7;
    b = 4'h8;
    up_valid = 1'b1;
    step();
    up_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", down_valid, 0);
    chk("t5_rst_diff", diff, 0);
    chk("t5_rst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_up_ready", up_ready, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_no_stale", down_valid, 0);
      step();
    end
    run_op("t5_2m3", 4'd2, 4'd3, 4'hF, 1'b0, 1'b0);

    last_accept = -1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        da = (i >= 8) ? i - 16 : i;
        db = (j >= 8) ? j - 16 : j;
        d = da - db;
        es = (d > 7) || (d < -8);
        if (d > 7) d = 7;
        if (d < -8) d = -8;
        ed = W'(d);
        run_op("t6_all", W'(i), W'(j), ed, es, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
